// File: rtl/mcu_irq_ctrl.sv
// mcu_irq_ctrl: per-source level/edge interrupt capture with mask, driving an
// active-low MCU interrupt. Configured and acknowledged over the MCU byte
// stream (command byte on start, parameter/response bytes after it).
module mcu_irq_ctrl #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            data_in_strobe,
   input  logic            data_in_start,
   input  logic [7:0]      data_in,
   output logic [7:0]      data_out,
   output logic            cmd_active,
   input  logic [NSRC-1:0] int_src,
   output logic [NSRC-1:0] int_ack,
   output logic            int_out_n
);

   localparam logic [7:0] CMD_READ_STATUS = 8'h10;
   localparam logic [7:0] CMD_WRITE_MASK  = 8'h11;
   localparam logic [7:0] CMD_ACK         = 8'h12;
   localparam logic [7:0] CMD_WRITE_MODE  = 8'h13;

   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] mode_q, mode_d;
   logic [NSRC-1:0] src_prev_q;
   logic [NSRC-1:0] ack_q, ack_d;
   logic [NSRC-1:0] ack_clr;
   logic [3:0]      state_q, state_d;
   logic [7:0]      command_q, command_d;
   logic [7:0]      dout_q, dout_d;
   logic            cmd_active_q, cmd_active_d;
   logic            irq_n_q, irq_n_d;
   logic [NSRC-1:0] active;
   logic [2:0]      prio_idx;
   logic            prio_vld;

   assign active = pending_q & mask_q;

   // Lowest-index active source wins; scan downward so the last hit is the lowest.
   always_comb begin
      prio_idx = '0;
      prio_vld = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            prio_idx = 3'(i);
            prio_vld = 1'b1;
         end
      end
   end

   // Byte framing and command decode; byte index is the state counter value
   // at the time the strobe arrives.
   always_comb begin
      state_d      = state_q;
      command_d    = command_q;
      cmd_active_d = cmd_active_q;
      dout_d       = dout_q;
      mask_d       = mask_q;
      mode_d       = mode_q;
      ack_d        = '0;
      ack_clr      = '0;
      if (data_in_strobe) begin
         if (data_in_start) begin
            command_d    = data_in;
            state_d      = 4'd1;
            cmd_active_d = (data_in >= CMD_READ_STATUS) && (data_in <= CMD_WRITE_MODE);
         end else if (state_q != 4'd0) begin
            if (state_q != 4'd15) state_d = state_q + 4'd1;
            case (command_q)
               CMD_READ_STATUS: begin
                  case (state_q)
                     4'd1:    dout_d = 8'(pending_q);
                     4'd2:    dout_d = 8'(mask_q);
                     4'd3:    dout_d = {prio_vld, 4'b0000, prio_idx};
                     default: dout_d = 8'h00;
                  endcase
               end
               CMD_WRITE_MASK: if (state_q == 4'd1) mask_d = data_in[NSRC-1:0];
               CMD_ACK: begin
                  if (state_q == 4'd1) begin
                     ack_d   = data_in[NSRC-1:0];
                     ack_clr = data_in[NSRC-1:0];
                  end
               end
               CMD_WRITE_MODE: if (state_q == 4'd1) mode_d = data_in[NSRC-1:0];
               default: ;
            endcase
         end
      end
   end

   // Capture: level bits follow the input; edge bits are sticky, a new rising
   // edge overrides a same-cycle ack clear.
   always_comb begin
      pending_d = (~mode_q & int_src)
                | (mode_q & ((int_src & ~src_prev_q) | (pending_q & ~ack_clr)));
      irq_n_d   = ~|active;
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q    <= '0;
         mask_q       <= '1;
         mode_q       <= '0;
         src_prev_q   <= '0;
         ack_q        <= '0;
         state_q      <= 4'd0;
         command_q    <= 8'h00;
         dout_q       <= 8'h00;
         cmd_active_q <= 1'b0;
         irq_n_q      <= 1'b1;
      end else begin
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         mode_q       <= mode_d;
         src_prev_q   <= int_src;
         ack_q        <= ack_d;
         state_q      <= state_d;
         command_q    <= command_d;
         dout_q       <= dout_d;
         cmd_active_q <= cmd_active_d;
         irq_n_q      <= irq_n_d;
      end
   end

   assign data_out   = dout_q;
   assign cmd_active = cmd_active_q;
   assign int_ack    = ack_q;
   assign int_out_n  = irq_n_q;

endmodule
